// File: rtl/riscv_wb_loadq.sv
// -----------------------------------------------------------------------------
// riscv_wb_loadq
//
// Non-blocking data-memory write-back unit. MEM pushes load/store descriptors
// into an in-order tracking queue. Each data-memory response retires the queue
// head and produces one registered write-back: aligned and extended load data,
// the register-file write enable, and a one-hot precise exception.
//
// Parameters
//   XLEN   data/address width, 32 or 64
//   DEPTH  maximum outstanding accesses, power of two, >= 2
//
// Configuration macro
//   RV_WBQ_FULL_BYPASS_EN  when defined, a full queue also accepts a push in a
//                          cycle where a response pops the head, which makes
//                          req_ready_o combinationally dependent on the dmem
//                          response strobes. When undefined, req_ready_o
//                          depends on the entry count only.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i/req_ready_o   request handshake, push on valid & ready
//   req_load_i                1 = load, 0 = store
//   req_func3_i               RISC-V funct3 (access size / unsigned)
//   req_adr_i, req_dst_i      access address, destination register
//   req_pc_i                  instruction PC
//   flush_i                   kill every queued entry (responses still drain)
//   dmem_ack_i, dmem_err_i,
//   dmem_misaligned_i,
//   dmem_page_fault_i         response strobes, any one retires the head
//   dmem_q_i                  load data, valid with dmem_ack_i
//   wb_valid_o                one access retired this cycle
//   wb_we_o, wb_dst_o, wb_r_o register-file write enable, index, data
//   wb_pc_o                   PC of the retired access
//   wb_exc_o                  {misaligned, page_fault, access_fault} one-hot
//   wb_badaddr_o              faulting address, 0 when no exception
//   occupancy_o               number of outstanding entries
// -----------------------------------------------------------------------------
module riscv_wb_loadq #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_load_i,
    input  logic [2:0]               req_func3_i,
    input  logic [XLEN-1:0]          req_adr_i,
    input  logic [4:0]               req_dst_i,
    input  logic [XLEN-1:0]          req_pc_i,
    input  logic                     flush_i,
    input  logic                     dmem_ack_i,
    input  logic                     dmem_err_i,
    input  logic                     dmem_misaligned_i,
    input  logic                     dmem_page_fault_i,
    input  logic [XLEN-1:0]          dmem_q_i,
    output logic                     wb_valid_o,
    output logic                     wb_we_o,
    output logic [4:0]               wb_dst_o,
    output logic [XLEN-1:0]          wb_r_o,
    output logic [XLEN-1:0]          wb_pc_o,
    output logic [2:0]               wb_exc_o,
    output logic [XLEN-1:0]          wb_badaddr_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // LD and LWU only exist on RV64; funct3 111 is never a load.
    function automatic logic f3_supported(input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b011, 3'b110: ok = (XLEN == 64);
            3'b111:         ok = 1'b0;
            default:        ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Move the addressed byte lane down to bit 0.
    function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] data,
                                                   input logic [2:0]      off);
        logic [5:0] sh;
        sh = {off, 3'b000};
        return data >> sh;
    endfunction

    // Sign- or zero-extend the aligned data according to funct3.
    function automatic logic [XLEN-1:0] extend_load(input logic [2:0]      f3,
                                                    input logic [XLEN-1:0] d);
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] w_s;
        logic [XLEN-1:0]    res;
        b_s = $signed(d[7:0]);
        h_s = $signed(d[15:0]);
        w_s = $signed(d[31:0]);
        case (f3)
            3'b000:  res = XLEN'(b_s);
            3'b001:  res = XLEN'(h_s);
            3'b010:  res = XLEN'(w_s);
            3'b011:  res = d;
            3'b100:  res = XLEN'(d[7:0]);
            3'b101:  res = XLEN'(d[15:0]);
            3'b110:  res = XLEN'(d[31:0]);
            default: res = '0;
        endcase
        return res;
    endfunction

    // Fixed priority: misaligned > page fault > access fault.
    function automatic logic [2:0] exc_encode(input logic mis,
                                              input logic pf,
                                              input logic err);
        logic [2:0] e;
        if (mis)      e = 3'b100;
        else if (pf)  e = 3'b010;
        else if (err) e = 3'b001;
        else          e = 3'b000;
        return e;
    endfunction

    // -------------------------------------------------------------------------
    // Queue control
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic resp;
    logic pop;
    logic push;

    assign resp = dmem_ack_i | dmem_err_i | dmem_misaligned_i | dmem_page_fault_i;
    // A response with nothing outstanding is a stray and is ignored.
    assign pop  = resp & (count_q != '0);
    assign push = req_valid_i & req_ready_o;

`ifdef RV_WBQ_FULL_BYPASS_EN
    assign req_ready_o = (count_q < CNT_W'(DEPTH)) | resp;
`else
    assign req_ready_o = (count_q < CNT_W'(DEPTH));
`endif

    assign occupancy_o = count_q;

    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage (no reset: validity is tracked by count_q)
    // -------------------------------------------------------------------------
    logic            ld_q   [DEPTH];
    logic [2:0]      f3_q   [DEPTH];
    logic [XLEN-1:0] adr_q  [DEPTH];
    logic [4:0]      dst_q  [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic            kill_q [DEPTH];

    always_ff @(posedge clk_i) begin
        // Marking every slot is cheaper than qualifying with occupancy; a
        // free slot gets its kill bit rewritten when it is next pushed.
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                kill_q[i] <= 1'b1;
            end
        end
        if (push) begin
            ld_q[tail_q]   <= req_load_i;
            f3_q[tail_q]   <= req_func3_i;
            adr_q[tail_q]  <= req_adr_i;
            dst_q[tail_q]  <= req_dst_i;
            pc_q[tail_q]   <= req_pc_i;
            kill_q[tail_q] <= flush_i;
        end
    end

    // -------------------------------------------------------------------------
    // Retire: decode the head entry against the current response
    // -------------------------------------------------------------------------
    logic            h_ld;
    logic [2:0]      h_f3;
    logic [XLEN-1:0] h_adr;
    logic [4:0]      h_dst;
    logic [XLEN-1:0] h_pc;
    logic            h_kill;
    logic [2:0]      h_off;

    assign h_ld   = ld_q[head_q];
    assign h_f3   = f3_q[head_q];
    assign h_adr  = adr_q[head_q];
    assign h_dst  = dst_q[head_q];
    assign h_pc   = pc_q[head_q];
    // A flush in the retire cycle also silences the head being retired.
    assign h_kill = kill_q[head_q] | flush_i;
    assign h_off  = (XLEN == 64) ? h_adr[2:0] : {1'b0, h_adr[1:0]};

    logic            wb_valid_q, wb_valid_d;
    logic            wb_we_q,    wb_we_d;
    logic [4:0]      wb_dst_q,   wb_dst_d;
    logic [XLEN-1:0] wb_r_q,     wb_r_d;
    logic [XLEN-1:0] wb_pc_q,    wb_pc_d;
    logic [2:0]      wb_exc_q,   wb_exc_d;
    logic [XLEN-1:0] wb_bad_q,   wb_bad_d;
    logic [2:0]      retire_exc;
    logic            retire_ok;

    always_comb begin
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_dst_d   = '0;
        wb_r_d     = '0;
        wb_pc_d    = '0;
        wb_exc_d   = '0;
        wb_bad_d   = '0;
        retire_exc = exc_encode(dmem_misaligned_i, dmem_page_fault_i, dmem_err_i);
        retire_ok  = !h_ld || f3_supported(h_f3);
        if (pop && !h_kill) begin
            wb_valid_d = 1'b1;
            wb_dst_d   = h_dst;
            wb_pc_d    = h_pc;
            // An unsupported load width retires as a harmless no-op.
            if (retire_ok) begin
                wb_exc_d = retire_exc;
                if (retire_exc != 3'b000) begin
                    wb_bad_d = h_adr;
                end else if (h_ld) begin
                    wb_r_d  = extend_load(h_f3, align_load(dmem_q_i, h_off));
                    wb_we_d = (h_dst != 5'd0);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered write-back outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_dst_q   <= '0;
            wb_r_q     <= '0;
            wb_pc_q    <= '0;
            wb_exc_q   <= '0;
            wb_bad_q   <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_dst_q   <= wb_dst_d;
            wb_r_q     <= wb_r_d;
            wb_pc_q    <= wb_pc_d;
            wb_exc_q   <= wb_exc_d;
            wb_bad_q   <= wb_bad_d;
        end
    end

    assign wb_valid_o   = wb_valid_q;
    assign wb_we_o      = wb_we_q;
    assign wb_dst_o     = wb_dst_q;
    assign wb_r_o       = wb_r_q;
    assign wb_pc_o      = wb_pc_q;
    assign wb_exc_o     = wb_exc_q;
    assign wb_badaddr_o = wb_bad_q;

endmodule

// File: tb/tb_riscv_wb_loadq.sv
// -----------------------------------------------------------------------------
// tb_riscv_wb_loadq
//
// Drives an XLEN=32 and an XLEN=64 instance of riscv_wb_loadq with identical
// directed stimulus. A queue-based reference model predicts every output each
// cycle; literal checks at key points pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_riscv_wb_loadq;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic        req_load;
    logic [2:0]  req_f3;
    logic [63:0] req_adr;
    logic [4:0]  req_dst;
    logic [63:0] req_pc;
    logic        flush;
    logic        ack, err, mis, pf;
    logic [63:0] dq;

    logic        rdy32, v32, we32;
    logic [4:0]  dst32;
    logic [31:0] r32, pc32, bad32;
    logic [2:0]  exc32;
    logic [2:0]  occ32;

    logic        rdy64, v64, we64;
    logic [4:0]  dst64;
    logic [63:0] r64, pc64, bad64;
    logic [2:0]  exc64;
    logic [2:0]  occ64;

    riscv_wb_loadq #(.XLEN(32), .DEPTH(DEPTH)) u32 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(rdy32),
        .req_load_i(req_load), .req_func3_i(req_f3),
        .req_adr_i(req_adr[31:0]), .req_dst_i(req_dst), .req_pc_i(req_pc[31:0]),
        .flush_i(flush),
        .dmem_ack_i(ack), .dmem_err_i(err),
        .dmem_misaligned_i(mis), .dmem_page_fault_i(pf),
        .dmem_q_i(dq[31:0]),
        .wb_valid_o(v32), .wb_we_o(we32), .wb_dst_o(dst32), .wb_r_o(r32),
        .wb_pc_o(pc32), .wb_exc_o(exc32), .wb_badaddr_o(bad32),
        .occupancy_o(occ32)
    );

    riscv_wb_loadq #(.XLEN(64), .DEPTH(DEPTH)) u64 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(rdy64),
        .req_load_i(req_load), .req_func3_i(req_f3),
        .req_adr_i(req_adr), .req_dst_i(req_dst), .req_pc_i(req_pc),
        .flush_i(flush),
        .dmem_ack_i(ack), .dmem_err_i(err),
        .dmem_misaligned_i(mis), .dmem_page_fault_i(pf),
        .dmem_q_i(dq),
        .wb_valid_o(v64), .wb_we_o(we64), .wb_dst_o(dst64), .wb_r_o(r64),
        .wb_pc_o(pc64), .wb_exc_o(exc64), .wb_badaddr_o(bad64),
        .occupancy_o(occ64)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        killed;
        logic        load;
        logic [2:0]  f3;
        logic [63:0] adr;
        logic [4:0]  dst;
        logic [63:0] pc;
    } ent_t;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [4:0]  dst;
        logic [63:0] r;
        logic [63:0] pc;
        logic [2:0]  exc;
        logic [63:0] bad;
    } wb_t;

    ent_t mq[$];
    wb_t  e32, e64;
    bit   started = 0;

    function automatic logic [63:0] trunc(input int xl, input logic [63:0] x);
        return (xl == 32) ? {32'b0, x[31:0]} : x;
    endfunction

    // Loaded value from plain byte arithmetic: pick 2^f3[1:0] bytes starting
    // at the address offset within the data word, then extend.
    function automatic logic [63:0] ext_val(input int xl, input logic [2:0] f3,
                                            input logic [63:0] adr, input logic [63:0] q,
                                            output bit ok);
        int          off;
        int          nb;
        logic [63:0] s, m, v;
        off = (xl == 64) ? int'(adr[2:0]) : int'(adr[1:0]);
        nb  = 1 << f3[1:0];
        s   = trunc(xl, q) >> (8 * off);
        m   = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        v   = s & m;
        if (!f3[2] && v[8*nb-1]) v = v | ~m;
        ok  = (f3 != 3'd7) && !(xl == 32 && (nb == 8 || f3 == 3'd6));
        return ok ? trunc(xl, v) : 64'd0;
    endfunction

    function automatic wb_t retire(input int xl, input ent_t e,
                                   input logic m_mis, input logic m_pf, input logic m_err,
                                   input logic [63:0] q);
        wb_t         w;
        bit          ok;
        logic [63:0] v;
        w = '0;
        if (e.killed) return w;
        w.v   = 1'b1;
        w.dst = e.dst;
        w.pc  = trunc(xl, e.pc);
        v = ext_val(xl, e.f3, e.adr, q, ok);
        if (e.load && !ok) return w;
        if (m_mis)      w.exc = 3'b100;
        else if (m_pf)  w.exc = 3'b010;
        else if (m_err) w.exc = 3'b001;
        if (w.exc != 3'b000) begin
            w.bad = trunc(xl, e.adr);
        end else if (e.load) begin
            w.r  = v;
            w.we = (e.dst != 5'd0);
        end
        return w;
    endfunction

    function automatic bit model_ready();
        bit r;
        r = (mq.size() < DEPTH);
`ifdef RV_WBQ_FULL_BYPASS_EN
        r = r | ack | err | mis | pf;
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        ent_t e;
        bit   resp;
        bit   rdy;
        if (rst) begin
            mq.delete();
            e32 = '0;
            e64 = '0;
            started = 1;
        end else begin
            resp = ack | err | mis | pf;
            rdy  = model_ready();
            if (flush) begin
                foreach (mq[i]) mq[i].killed = 1'b1;
            end
            e32 = '0;
            e64 = '0;
            if (resp && mq.size() > 0) begin
                e = mq.pop_front();
                if (flush) e.killed = 1'b1;
                e32 = retire(32, e, mis, pf, err, dq);
                e64 = retire(64, e, mis, pf, err, dq);
            end
            if (req_valid && rdy) begin
                mq.push_back({flush, req_load, req_f3, req_adr, req_dst, req_pc});
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("v32",    64'(v32),   64'(e32.v));
            chk("we32",   64'(we32),  64'(e32.we));
            chk("dst32",  64'(dst32), 64'(e32.dst));
            chk("r32",    64'(r32),   e32.r);
            chk("pc32",   64'(pc32),  e32.pc);
            chk("exc32",  64'(exc32), 64'(e32.exc));
            chk("bad32",  64'(bad32), e32.bad);
            chk("rdy32",  64'(rdy32), 64'(model_ready()));
            chk("occ32",  64'(occ32), 64'(mq.size()));
            chk("v64",    64'(v64),   64'(e64.v));
            chk("we64",   64'(we64),  64'(e64.we));
            chk("dst64",  64'(dst64), 64'(e64.dst));
            chk("r64",    r64,        e64.r);
            chk("pc64",   pc64,       e64.pc);
            chk("exc64",  64'(exc64), 64'(e64.exc));
            chk("bad64",  bad64,      e64.bad);
            chk("rdy64",  64'(rdy64), 64'(model_ready()));
            chk("occ64",  64'(occ64), 64'(mq.size()));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 0; req_load = 0; req_f3 = 0; req_adr = 0; req_dst = 0; req_pc = 0;
        flush = 0; ack = 0; err = 0; mis = 0; pf = 0; dq = 0;
    endtask

    task automatic set_req(input logic ld, input logic [2:0] f3, input logic [63:0] adr,
                           input logic [4:0] dst, input logic [63:0] pc);
        req_valid = 1; req_load = ld; req_f3 = f3; req_adr = adr; req_dst = dst; req_pc = pc;
    endtask

    task automatic push1(input logic ld, input logic [2:0] f3, input logic [63:0] adr,
                         input logic [4:0] dst, input logic [63:0] pc);
        set_req(ld, f3, adr, dst, pc);
        cyc();
        req_valid = 0;
    endtask

    task automatic resp1(input logic a, input logic e, input logic m, input logic p,
                         input logic [63:0] q);
        ack = a; err = e; mis = m; pf = p; dq = q;
        cyc();
        ack = 0; err = 0; mis = 0; pf = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        chk("rst_occ",   64'(occ32), 64'd0);
        chk("rst_ready", 64'(rdy32), 64'd1);
        chk("rst_valid", 64'(v64),   64'd0);

        // Byte loads with sign and zero extension.
        push1(1, 3'b000, 64'h1003, 5'd5, 64'h100);
        resp1(1, 0, 0, 0, 64'h80FF_1234);
        chk("lb_r32",   64'(r32),  64'hFFFF_FF80);
        chk("lb_we32",  64'(we32), 64'd1);
        chk("lb_dst32", 64'(dst32), 64'd5);
        chk("lb_r64",   r64,       64'hFFFF_FFFF_FFFF_FF80);
        push1(1, 3'b100, 64'h1003, 5'd6, 64'h104);
        resp1(1, 0, 0, 0, 64'h80FF_1234);
        chk("lbu_r32",  64'(r32),  64'h0000_0080);

        // Fill the queue, then drain with back-to-back acks.
        for (int i = 1; i <= 4; i++) begin
            set_req(1, 3'b010, 64'h40 + 64'(4 * i), 5'(i), 64'h200 + 64'(4 * i));
            cyc();
        end
        req_valid = 0;
        chk("full_occ",   64'(occ32), 64'd4);
        chk("full_ready", 64'(rdy32), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            ack = 1;
            dq  = 64'(k);
            if (k == 1) set_req(1, 3'b010, 64'h80, 5'd9, 64'h300);
            else        req_valid = 0;
            cyc();
            if (k <= 4) begin
                chk("drain_valid", 64'(v32),   64'd1);
                chk("drain_dst",   64'(dst32), 64'(k));
            end
            if (k == 1) begin
`ifdef RV_WBQ_FULL_BYPASS_EN
                chk("bypass_occ", 64'(occ32), 64'd4);
`else
                chk("stall_occ",  64'(occ32), 64'd3);
`endif
            end
            if (k == 5) begin
`ifdef RV_WBQ_FULL_BYPASS_EN
                chk("bypass_dst", 64'(dst32), 64'd9);
`else
                chk("stray_valid", 64'(v32), 64'd0);
`endif
            end
        end
        ack = 0;
        req_valid = 0;
        cyc();

        // Exceptions and their priority.
        push1(1, 3'b010, 64'h2001, 5'd7, 64'h400);
        resp1(0, 1, 1, 0, 64'h0);
        chk("exc_code",  64'(exc32), 64'h4);
        chk("exc_bad",   64'(bad32), 64'h2001);
        chk("exc_we",    64'(we32),  64'd0);
        chk("exc_valid", 64'(v32),   64'd1);
        push1(0, 3'b010, 64'h3000, 5'd0, 64'h404);
        resp1(0, 0, 0, 1, 64'h0);
        push1(1, 3'b001, 64'h3002, 5'd8, 64'h408);
        resp1(0, 1, 0, 0, 64'h0);
        chk("err_code",  64'(exc64), 64'h1);

        // Flush with entries outstanding.
        for (int i = 0; i < 3; i++) begin
            set_req(1, 3'b010, 64'h500 + 64'(4 * i), 5'(10 + i), 64'h500 + 64'(4 * i));
            cyc();
        end
        req_valid = 0;
        flush = 1;
        cyc();
        flush = 0;
        chk("flush_occ", 64'(occ32), 64'd3);
        for (int i = 0; i < 3; i++) begin
            resp1(1, 0, 0, 0, 64'hDEAD_BEEF);
            chk("flush_silent", 64'(v32), 64'd0);
        end
        chk("flush_empty", 64'(occ32), 64'd0);
        push1(1, 3'b010, 64'h50, 5'd13, 64'h600);
        resp1(1, 0, 0, 0, 64'h1234_5678);
        chk("post_flush_valid", 64'(v32),   64'd1);
        chk("post_flush_dst",   64'(dst32), 64'd13);
        chk("post_flush_r",     64'(r32),   64'h1234_5678);

        // RV64 widths and x0 destination.
        push1(1, 3'b011, 64'h8, 5'd3, 64'h700);
        resp1(1, 0, 0, 0, 64'h8000_0000_0000_0001);
        chk("ld_r64",   r64,        64'h8000_0000_0000_0001);
        chk("ld_we64",  64'(we64),  64'd1);
        chk("ld_r32",   64'(r32),   64'd0);
        chk("ld_we32",  64'(we32),  64'd0);
        chk("ld_v32",   64'(v32),   64'd1);
        push1(1, 3'b010, 64'h8, 5'd4, 64'h704);
        resp1(1, 0, 0, 0, 64'h8000_0000_0000_0001);
        chk("lw_r64",   r64,        64'h1);
        push1(1, 3'b010, 64'h8, 5'd0, 64'h708);
        resp1(1, 0, 0, 0, 64'h0000_0000_8000_0000);
        chk("x0_v64",   64'(v64),   64'd1);
        chk("x0_we64",  64'(we64),  64'd0);
        push1(1, 3'b110, 64'h4, 5'd12, 64'h70C);
        resp1(1, 0, 0, 0, 64'hFFFF_FFFF_0000_0000);
        chk("lwu_r64",  r64,        64'h0000_0000_FFFF_FFFF);
        push1(1, 3'b111, 64'h0, 5'd14, 64'h710);
        resp1(1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        push1(1, 3'b001, 64'h2, 5'd15, 64'h714);
        resp1(1, 0, 0, 0, 64'h0000_0000_8001_0000);
        chk("lh_r32",   64'(r32),   64'hFFFF_8001);
        push1(0, 3'b010, 64'h20, 5'd16, 64'h718);
        resp1(1, 0, 0, 0, 64'h1111_1111);

        // Push and response in the same cycle.
        push1(1, 3'b010, 64'h60, 5'd20, 64'h800);
        set_req(1, 3'b010, 64'h64, 5'd21, 64'h804);
        resp1(1, 0, 0, 0, 64'hA5A5_A5A5);
        req_valid = 0;
        chk("pr_occ", 64'(occ32), 64'd1);
        chk("pr_dst", 64'(dst32), 64'd20);
        resp1(1, 0, 0, 0, 64'h5A5A_5A5A);
        chk("pr_dst2", 64'(dst32), 64'd21);

        // Reset with entries outstanding, then a stray response.
        push1(1, 3'b010, 64'h70, 5'd22, 64'h900);
        push1(1, 3'b010, 64'h74, 5'd23, 64'h904);
        rst = 1;
        cyc();
        rst = 0;
        resp1(1, 0, 0, 0, 64'h1);
        chk("stray_v",   64'(v32),   64'd0);
        chk("stray_occ", 64'(occ32), 64'd0);
        push1(1, 3'b000, 64'h1, 5'd24, 64'h908);
        resp1(1, 0, 0, 0, 64'h0000_7F00);
        chk("after_rst_r", 64'(r32), 64'h7F);

        cyc();
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
